// File: rtl/ysyx_24110015_mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM states, owner codes and
// the latched memory request record.
package ysyx_24110015_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } arb_state_e;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic [3:0]  wmask;
  } mem_req_t;

  // LSU wins when it is the only requester, or on a tie when lsu_first is set.
  function automatic logic pick_lsu(input logic ifu_v, input logic lsu_v,
                                    input logic lsu_first);
    return lsu_v && (!ifu_v || lsu_first);
  endfunction

endpackage

// File: rtl/ysyx_24110015_mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter onto a single-outstanding memory port.
// One transaction at a time: IDLE -> REQ -> WAIT -> RESP -> IDLE.
module ysyx_24110015_mem_arbiter
  import ysyx_24110015_mem_arbiter_pkg::*;
#(
  parameter bit LSU_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [31:0] ifu_rdata,

  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [31:0] lsu_rdata,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  output logic        mem_resp_ready,
  input  logic [31:0] mem_rdata,

  output logic        busy
);

  arb_state_e  state;
  logic        owner;
  mem_req_t    req_q;
  logic [31:0] resp_data;
  logic        grant_lsu;
  logic        grant_ifu;
  logic        owner_resp_ready;

  always_comb begin
    grant_lsu = pick_lsu(ifu_req_valid, lsu_req_valid, LSU_FIRST);
    grant_ifu = ifu_req_valid && !grant_lsu;
  end

  assign ifu_req_ready    = (state == S_IDLE) && grant_ifu;
  assign lsu_req_ready    = (state == S_IDLE) && grant_lsu;
  assign owner_resp_ready = (owner == OWNER_LSU) ? lsu_resp_ready : ifu_resp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      owner     <= OWNER_IFU;
      req_q     <= '0;
      resp_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (lsu_req_ready) begin
            owner       <= OWNER_LSU;
            req_q.addr  <= lsu_addr;
            req_q.wdata <= lsu_wdata;
            req_q.wen   <= lsu_wen;
            req_q.wmask <= lsu_wmask;
            state       <= S_REQ;
          end else if (ifu_req_ready) begin
            // Fetches are always plain reads.
            owner       <= OWNER_IFU;
            req_q.addr  <= ifu_addr;
            req_q.wdata <= '0;
            req_q.wen   <= 1'b0;
            req_q.wmask <= '0;
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            resp_data <= mem_rdata;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (owner_resp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem_req_valid  = (state == S_REQ);
  assign mem_resp_ready = (state == S_WAIT);
  assign mem_addr       = req_q.addr;
  assign mem_wdata      = req_q.wdata;
  assign mem_wen        = req_q.wen;
  assign mem_wmask      = req_q.wmask;

  assign ifu_resp_valid = (state == S_RESP) && (owner == OWNER_IFU);
  assign lsu_resp_valid = (state == S_RESP) && (owner == OWNER_LSU);
  assign ifu_rdata      = resp_data;
  assign lsu_rdata      = resp_data;

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ysyx_24110015_mem_arbiter.sv
// Arbiter bench: transaction-level reference model checked every cycle,
// directed scenarios, then randomized traffic with occasional resets.
module tb_ysyx_24110015_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A (LSU_FIRST=1)
  logic        ifu_req_valid = 0, ifu_req_ready, ifu_resp_valid, ifu_resp_ready = 1;
  logic [31:0] ifu_addr = 0, ifu_rdata;
  logic        lsu_req_valid = 0, lsu_req_ready, lsu_wen = 0, lsu_resp_valid, lsu_resp_ready = 1;
  logic [31:0] lsu_addr = 0, lsu_wdata = 0, lsu_rdata;
  logic [3:0]  lsu_wmask = 0;
  logic        mem_req_valid, mem_req_ready = 1, mem_wen, mem_resp_valid = 0, mem_resp_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [3:0]  mem_wmask;
  logic        busy;

  // DUT B (LSU_FIRST=0), used for the tie-break scenario only
  logic        b_ifu_req_valid = 0, b_ifu_req_ready, b_ifu_resp_valid, b_ifu_resp_ready = 1;
  logic [31:0] b_ifu_addr = 0, b_ifu_rdata;
  logic        b_lsu_req_valid = 0, b_lsu_req_ready, b_lsu_wen = 0, b_lsu_resp_valid, b_lsu_resp_ready = 1;
  logic [31:0] b_lsu_addr = 0, b_lsu_wdata = 0, b_lsu_rdata;
  logic [3:0]  b_lsu_wmask = 0;
  logic        b_mem_req_valid, b_mem_req_ready = 1, b_mem_wen, b_mem_resp_valid = 1, b_mem_resp_ready;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata = 32'h1111_2222;
  logic [3:0]  b_mem_wmask;
  logic        b_busy;

  ysyx_24110015_mem_arbiter dut_a (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  ysyx_24110015_mem_arbiter #(.LSU_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .ifu_req_valid(b_ifu_req_valid), .ifu_req_ready(b_ifu_req_ready), .ifu_addr(b_ifu_addr),
    .ifu_resp_valid(b_ifu_resp_valid), .ifu_resp_ready(b_ifu_resp_ready), .ifu_rdata(b_ifu_rdata),
    .lsu_req_valid(b_lsu_req_valid), .lsu_req_ready(b_lsu_req_ready), .lsu_addr(b_lsu_addr),
    .lsu_wen(b_lsu_wen), .lsu_wdata(b_lsu_wdata), .lsu_wmask(b_lsu_wmask),
    .lsu_resp_valid(b_lsu_resp_valid), .lsu_resp_ready(b_lsu_resp_ready), .lsu_rdata(b_lsu_rdata),
    .mem_req_valid(b_mem_req_valid), .mem_req_ready(b_mem_req_ready), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_wen(b_mem_wen), .mem_wmask(b_mem_wmask),
    .mem_resp_valid(b_mem_resp_valid), .mem_resp_ready(b_mem_resp_ready), .mem_rdata(b_mem_rdata),
    .busy(b_busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model for DUT A: one outstanding transaction record with the
  // progress flags "sent to memory" and "response captured".
  bit          chk_en = 0;
  logic        m_act = 0, m_own = 0, m_sent = 0, m_got = 0, m_wen = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_resp = 0;
  logic [3:0]  m_wmask = 0;
  logic        e_ifu_rdy, e_lsu_rdy;

  task automatic model_step();
    e_lsu_rdy = !m_act && lsu_req_valid && !ifu_req_valid
             || !m_act && lsu_req_valid && ifu_req_valid;
    e_ifu_rdy = !m_act && ifu_req_valid && !lsu_req_valid;
    chk("ifu_req_ready", ifu_req_ready, e_ifu_rdy);
    chk("lsu_req_ready", lsu_req_ready, e_lsu_rdy);
    chk("busy", busy, m_act);
    chk("mem_req_valid", mem_req_valid, m_act && !m_sent);
    chk("mem_resp_ready", mem_resp_ready, m_act && m_sent && !m_got);
    chk("ifu_resp_valid", ifu_resp_valid, m_got && !m_own);
    chk("lsu_resp_valid", lsu_resp_valid, m_got && m_own);
    if (m_act) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wen", mem_wen, m_wen);
      chk("mem_wmask", mem_wmask, m_wmask);
      if (m_own) chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (m_got) begin
      chk("ifu_rdata", ifu_rdata, m_resp);
      chk("lsu_rdata", lsu_rdata, m_resp);
    end
    if (rst) begin
      m_act = 0; m_sent = 0; m_got = 0;
    end else if (m_got) begin
      if (m_own ? lsu_resp_ready : ifu_resp_ready) begin
        m_act = 0; m_sent = 0; m_got = 0;
      end
    end else if (m_sent) begin
      if (mem_resp_valid) begin m_got = 1; m_resp = mem_rdata; end
    end else if (m_act) begin
      if (mem_req_ready) m_sent = 1;
    end else if (e_lsu_rdy) begin
      m_act = 1; m_own = 1; m_addr = lsu_addr; m_wen = lsu_wen;
      m_wdata = lsu_wdata; m_wmask = lsu_wmask;
    end else if (e_ifu_rdy) begin
      m_act = 1; m_own = 0; m_addr = ifu_addr; m_wen = 0; m_wmask = 0;
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) model_step();
  end

  task automatic idle_inputs();
    ifu_req_valid = 0; lsu_req_valid = 0;
    ifu_resp_ready = 1; lsu_resp_ready = 1;
    mem_req_ready = 1; mem_resp_valid = 1;
  endtask

  task automatic drain();
    idle_inputs();
    for (int i = 0; i < 20 && busy; i++) tick();
    mem_resp_valid = 0;
    chk("drain_idle", busy, 1'b0);
  endtask

  int cyc;

  initial begin
    tick(); tick();
    rst = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_resp_ready", mem_resp_ready, 0);
    chk("rst_ifu_resp_valid", ifu_resp_valid, 0);
    chk("rst_lsu_resp_valid", lsu_resp_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_rdata", ifu_rdata, 0);
    chk_en = 1;

    // Tie-break with LSU_FIRST=0: IFU first, LSU accepted four cycles later
    b_ifu_req_valid = 1; b_ifu_addr = 32'h8000_0000;
    b_lsu_req_valid = 1; b_lsu_addr = 32'h8000_1000;
    #1;
    chk("b_tie_ifu_rdy", b_ifu_req_ready, 1);
    chk("b_tie_lsu_rdy", b_lsu_req_ready, 0);
    tick();
    b_ifu_req_valid = 0;
    #1;
    chk("b_first_addr", b_mem_addr, 32'h8000_0000);
    cyc = 1;
    while (!b_lsu_req_ready && cyc < 10) begin tick(); cyc++; end
    chk("b_lsu_accept_cyc", cyc, 4);
    tick();
    b_lsu_req_valid = 0;
    #1;
    chk("b_second_addr", b_mem_addr, 32'h8000_1000);

    // Minimum latency IFU fetch
    drain();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
    mem_resp_valid = 1; mem_rdata = 32'h0010_0073;
    #1; chk("lat_t0_accept", ifu_req_ready, 1);
    tick(); ifu_req_valid = 0;
    #1; chk("lat_t1_mem_req", mem_req_valid, 1);
    tick(); #1; chk("lat_t2_mem_resp_rdy", mem_resp_ready, 1);
    tick(); #1;
    chk("lat_t3_ifu_resp", ifu_resp_valid, 1);
    chk("lat_t3_rdata", ifu_rdata, 32'h0010_0073);
    chk("lat_t3_lsu_quiet", lsu_resp_valid, 0);
    tick(); #1; chk("lat_t4_idle", busy, 0);

    // Tie-break with LSU_FIRST=1
    drain();
    lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 0;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
    mem_resp_valid = 1; mem_rdata = 32'h5555_aaaa;
    #1;
    chk("a_tie_lsu_rdy", lsu_req_ready, 1);
    chk("a_tie_ifu_rdy", ifu_req_ready, 0);
    tick(); lsu_req_valid = 0; #1;
    cyc = 1;
    while (!ifu_req_ready && cyc < 10) begin tick(); cyc++; end
    chk("a_ifu_accept_cyc", cyc, 4);
    tick(); ifu_req_valid = 0; #1;
    chk("a_second_addr", mem_addr, 32'h8000_0004);

    // Store with memory stalling the request for three cycles
    drain();
    lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_0010;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'h3; mem_req_ready = 0;
    tick();
    lsu_req_valid = 0; lsu_wen = 0; lsu_addr = $urandom; lsu_wdata = $urandom; lsu_wmask = 4'hc;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_req_valid", mem_req_valid, 1);
      chk("st_addr", mem_addr, 32'h8000_0010);
      chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("st_wen", mem_wen, 1);
      chk("st_wmask", mem_wmask, 4'h3);
      tick();
    end
    drain();

    // Reset while waiting on memory drops the transaction
    lsu_req_valid = 1; lsu_addr = 32'h8000_2000; mem_resp_valid = 0;
    tick(); lsu_req_valid = 0;
    tick(); #1; chk("rw_in_wait", mem_resp_ready, 1);
    rst = 1; tick(); rst = 0; #1;
    chk("rw_busy", busy, 0);
    chk("rw_mem_req_valid", mem_req_valid, 0);
    chk("rw_mem_resp_ready", mem_resp_ready, 0);
    chk("rw_lsu_resp_valid", lsu_resp_valid, 0);
    chk("rw_ifu_resp_valid", ifu_resp_valid, 0);
    mem_resp_valid = 1; mem_rdata = 32'h1234_5678;
    tick(); #1;
    chk("rw_stray_busy", busy, 0);
    chk("rw_stray_rdata", lsu_rdata, 0);
    mem_resp_valid = 0;

    // Owner holds off the response for five cycles
    drain();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0040; ifu_resp_ready = 0;
    mem_resp_valid = 1; mem_rdata = 32'hCAFE_F00D;
    tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      mem_rdata = $urandom;
      #1;
      chk("hold_valid", ifu_resp_valid, 1);
      chk("hold_rdata", ifu_rdata, 32'hCAFE_F00D);
      chk("hold_no_accept", ifu_req_ready, 0);
      tick();
    end
    ifu_req_valid = 0;
    drain();

    // Randomized traffic; the model checks every cycle
    for (int i = 0; i < 2000; i++) begin
      rst            = ($urandom_range(0, 63) == 0);
      ifu_req_valid  = $urandom_range(0, 1);
      lsu_req_valid  = $urandom_range(0, 1);
      ifu_addr       = $urandom;
      lsu_addr       = $urandom;
      lsu_wen        = $urandom_range(0, 1);
      lsu_wdata      = $urandom;
      lsu_wmask      = 4'($urandom);
      ifu_resp_ready = ($urandom_range(0, 9) < 7);
      lsu_resp_ready = ($urandom_range(0, 9) < 7);
      mem_req_ready  = ($urandom_range(0, 9) < 6);
      mem_resp_valid = ($urandom_range(0, 9) < 5);
      mem_rdata      = $urandom;
      tick();
    end
    rst = 0;
    drain();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_24110015_mem_arbiter.md
YSYX_24110015_MEM_ARBITER -- requirements
Module: ysyx_24110015_mem_arbiter

Interface
REQ-001 Parameter LSU_FIRST, default 1, SHALL select the tie-break: 1 = LSU wins simultaneous requests, 0 = IFU wins.
REQ-002 One clock; reset is synchronous and active-high: clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 ifu_req_valid  in  1  IFU fetch request.
REQ-005 ifu_req_ready  out  1  IFU request accepted this cycle.
REQ-006 ifu_addr  in  32  fetch address.
REQ-007 ifu_resp_valid  out  1  fetch data available.
REQ-008 ifu_resp_ready  in  1  IFU takes the response.
REQ-009 ifu_rdata  out  32  fetched instruction.
REQ-010 lsu_req_valid  in  1  LSU load/store request.
REQ-011 lsu_req_ready  out  1  LSU request accepted this cycle.
REQ-012 lsu_addr  in  32  access address.
REQ-013 lsu_wen  in  1  1 = store, 0 = load.
REQ-014 lsu_wdata  in  32  store data.
REQ-015 lsu_wmask  in  4  store byte enables.
REQ-016 lsu_resp_valid  out  1  load data, or store completion.
REQ-017 lsu_resp_ready  in  1  LSU takes the response.
REQ-018 lsu_rdata  out  32  load data.
REQ-019 mem_req_valid / mem_req_ready  out / in  1 / 1  memory request handshake.
REQ-020 mem_addr, mem_wdata  out  32 each; mem_wen  out  1; mem_wmask  out  4: latched request fields.
REQ-021 mem_resp_valid / mem_resp_ready  in / out  1 / 1  memory response handshake.
REQ-022 mem_rdata  in  32  memory read data.
REQ-023 busy  out  1  high in every state except IDLE.

Function
REQ-024 The FSM SHALL have four states: IDLE, REQ, WAIT and RESP, plus a 1-bit owner register (0 = IFU, 1 = LSU).
REQ-025 In IDLE, only the winning requester's req_ready SHALL be high, combinationally; both req_ready outputs SHALL be 0 in all other states.
- Winner is the only valid requester, or the one chosen by LSU_FIRST when both are valid.
REQ-026 A request handshake in IDLE SHALL latch owner, addr, wen, wdata and wmask, and move to REQ. IFU requests latch wen=0 and wmask=0.
REQ-027 In REQ, mem_req_valid SHALL be 1 with the latched fields held stable; mem_req_ready=1 moves to WAIT.
REQ-028 In WAIT, mem_resp_ready SHALL be 1; mem_resp_valid=1 latches mem_rdata into resp_data and moves to RESP.
REQ-029 In RESP, only the owner's resp_valid SHALL be 1. The owner's resp_ready=1 moves to IDLE.
REQ-030 ifu_rdata and lsu_rdata SHALL both equal resp_data; the data is meaningful only while the matching resp_valid is high.
REQ-031 Minimum transaction SHALL take 4 cycles: accept at T, mem request at T+1, mem response at T+2, owner response at T+3. The next accept is possible at T+4.
REQ-032 A requester waiting in any non-IDLE state SHALL stay stalled; it is not queued, and re-arbitration happens on the IDLE cycle.
REQ-033 mem_resp_valid outside WAIT SHALL be ignored and SHALL NOT change state or resp_data.
REQ-034 Stalls on mem_req_ready, mem_resp_valid or owner resp_ready SHALL hold the state indefinitely, with no timeout.

Reset
REQ-035 While rst=1 at a clock edge: state=IDLE, owner=0, and all latched fields and resp_data = 0.
REQ-036 After reset, mem_req_valid, mem_resp_ready, both resp_valid and busy SHALL be 0.
REQ-037 Reset during REQ, WAIT or RESP SHALL silently drop the transaction; no response is delivered.

Structure
REQ-038 The shared package SHALL hold the state enum (IDLE/REQ/WAIT/RESP) and the owner constants OWNER_IFU=0 and OWNER_LSU=1.
REQ-039 The design SHALL be a single module with no sub-module; the priority pick is inline logic.

Verification
REQ-040 IFU only, addr=0x80000000, memory ready at once returning 0x00100073 -> ifu_resp_valid at T+3 with ifu_rdata=0x00100073; lsu_resp_valid stays 0.
REQ-041 Both requesters valid in the same cycle, LSU_FIRST=1, LSU load at 0x80001000 -> LSU granted first; IFU accepted on the IDLE cycle after lsu_resp handshake.
REQ-042 Same as REQ-041 with LSU_FIRST=0 -> IFU is served first.
REQ-043 LSU store addr=0x80000010, wdata=0xDEADBEEF, wmask=0x3, with mem_req_ready held low for 3 cycles -> mem outputs stable throughout; mem_wen=1 and mem_wmask=0x3.
REQ-044 rst asserted in WAIT -> next cycle IDLE with every valid and busy = 0; a later stray mem_resp_valid is ignored.
REQ-045 Owner holds resp_ready=0 for 5 cycles -> resp_valid and rdata held constant; no new request is accepted.
